// File: rtl/seq_mon_pkg.sv
// Shared state encoding for the detector hit monitor.
package seq_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WATCH = 2'b01,
    ALARM = 2'b10
  } mon_state_e;

  localparam logic [1:0] ST_ILLEGAL = 2'b11;

endpackage

// File: rtl/seq_win_timer.sv
// Observation window counter 0..WIN_LEN-1 with clear/hold; flags the final window cycle.
module seq_win_timer #(
  parameter int unsigned WIN_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic last_c
);

  localparam int unsigned TW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      timer <= '0;
    end else if (!hold) begin
      timer <= last_c ? '0 : timer + TW'(1);
    end
  end

  assign last_c = (timer == TW'(WIN_LEN - 1));

endmodule

// File: rtl/seq_hit_monitor.sv
// Counts "101" detector hits in total and per window; raises a sticky alarm at THRESH hits.
// Optional one-cycle alarm_irq pulse when SEQ_HIT_MONITOR_IRQ_PULSE_EN is defined.
module seq_hit_monitor
  import seq_mon_pkg::*;
#(
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned THRESH  = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         det,
  input  logic                         clr,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [$clog2(THRESH+1)-1:0]  win_cnt,
  output logic                         alarm,
`ifdef SEQ_HIT_MONITOR_IRQ_PULSE_EN
  output logic                         alarm_irq,
`endif
  output logic [1:0]                   state_o
);

  localparam int unsigned WC_W = $clog2(THRESH + 1);

  mon_state_e       state, state_nxt;
  logic [CNT_W-1:0] hit_nxt;
  logic [WC_W-1:0]  win_nxt;
  logic             alarm_nxt;
  logic             tmr_clr, tmr_hold;
  logic             last_c;
  logic             hit_c;
  logic [WC_W:0]    win_sum_c;
  logic             thr_c;

  assign hit_c     = en & det;
  assign win_sum_c = {1'b0, win_cnt} + (WC_W+1)'(hit_c);
  assign thr_c     = (win_sum_c >= (WC_W+1)'(THRESH));

  seq_win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .hold   (tmr_hold),
    .last_c (last_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hit_cnt <= '0;
      win_cnt <= '0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_nxt;
      hit_cnt <= hit_nxt;
      win_cnt <= win_nxt;
      alarm   <= alarm_nxt;
    end
  end

  // Priority inside WATCH/ALARM: en=0 > clr > threshold > window wrap
  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    win_nxt   = win_cnt;
    alarm_nxt = alarm;
    tmr_clr   = 1'b0;
    tmr_hold  = 1'b0;
    case (state)
      IDLE: begin
        win_nxt   = '0;
        alarm_nxt = 1'b0;
        tmr_clr   = 1'b1;
        if (en) state_nxt = WATCH;
      end
      WATCH, ALARM: begin
        if (hit_c && (hit_cnt != '1)) hit_nxt = hit_cnt + CNT_W'(1);
        if (!en) begin
          state_nxt = IDLE;
          win_nxt   = '0;
          alarm_nxt = 1'b0;
          tmr_clr   = 1'b1;
        end else if (clr) begin
          state_nxt = WATCH;
          win_nxt   = '0;
          alarm_nxt = 1'b0;
          tmr_clr   = 1'b1;
        end else if (state == ALARM) begin
          tmr_hold = 1'b1;
        end else if (thr_c) begin
          state_nxt = ALARM;
          win_nxt   = WC_W'(THRESH);
          alarm_nxt = 1'b1;
          tmr_hold  = 1'b1;
        end else if (last_c) begin
          win_nxt = '0;
        end else begin
          win_nxt = win_sum_c[WC_W-1:0];
        end
      end
      default: begin
        state_nxt = IDLE;
        hit_nxt   = '0;
        win_nxt   = '0;
        alarm_nxt = 1'b0;
        tmr_clr   = 1'b1;
      end
    endcase
  end

  assign state_o = state;

`ifdef SEQ_HIT_MONITOR_IRQ_PULSE_EN
  always_ff @(posedge clk) begin
    if (rst) alarm_irq <= 1'b0;
    else     alarm_irq <= (state == WATCH) && (state_nxt == ALARM);
  end
`endif

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Scoreboard bench for seq_hit_monitor: directed test-plan sequences then random traffic.
module tb_seq_hit_monitor;

  localparam int unsigned WIN_LEN = 16;
  localparam int unsigned THRESH  = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned WC_W    = $clog2(THRESH + 1);
  localparam int          SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, det, clr;
  logic [CNT_W-1:0] hit_cnt;
  logic [WC_W-1:0]  win_cnt;
  logic             alarm;
  logic [1:0]       state_o;
`ifdef SEQ_HIT_MONITOR_IRQ_PULSE_EN
  logic             alarm_irq;
`endif

  seq_hit_monitor #(.WIN_LEN(WIN_LEN), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .det     (det),
    .clr     (clr),
    .hit_cnt (hit_cnt),
    .win_cnt (win_cnt),
    .alarm   (alarm),
`ifdef SEQ_HIT_MONITOR_IRQ_PULSE_EN
    .alarm_irq (alarm_irq),
`endif
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hits;
    int win;
    int st;
    bit alarm;
    bit irq;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0 idle, 1 watching, 2 alarmed
  int m_mode  = 0;
  int m_timer = 0;
  int m_win   = 0;
  int m_hits  = 0;
  bit m_alarm = 1'b0;
  bit m_irq   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit d, input bit c);
    exp_t x;
    int   h;
    @(negedge clk);
    rst = r; en = e; det = d; clr = c;
    m_irq = 1'b0;
    if (r) begin
      m_mode = 0; m_timer = 0; m_win = 0; m_hits = 0; m_alarm = 1'b0;
    end else if (m_mode == 0) begin
      m_timer = 0; m_win = 0; m_alarm = 1'b0;
      if (e) m_mode = 1;
    end else begin
      h = (e && d) ? 1 : 0;
      m_hits = (m_hits + h > SAT) ? SAT : m_hits + h;
      if (!e) begin
        m_mode = 0; m_timer = 0; m_win = 0; m_alarm = 1'b0;
      end else if (c) begin
        m_mode = 1; m_timer = 0; m_win = 0; m_alarm = 1'b0;
      end else if (m_mode == 2) begin
        // frozen while alarmed
      end else if (m_win + h >= THRESH) begin
        m_mode = 2; m_win = THRESH; m_alarm = 1'b1; m_irq = 1'b1;
      end else if (m_timer == WIN_LEN - 1) begin
        m_timer = 0; m_win = 0;
      end else begin
        m_timer++; m_win += h;
      end
    end
    x.hits = m_hits; x.win = m_win; x.alarm = m_alarm; x.irq = m_irq;
    x.st = (m_mode == 2) ? 2 : (m_mode == 1) ? 1 : 0;
    q.push_back(x);
  endtask

  task automatic window(input logic [15:0] m);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, m[i], 1'b0);
  endtask

  // Monitor: compare registered outputs just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("hit_cnt", int'(hit_cnt), e.hits);
        check("win_cnt", int'(win_cnt), e.win);
        check("alarm",   int'(alarm),   int'(e.alarm));
        check("state_o", int'(state_o), e.st);
`ifdef SEQ_HIT_MONITOR_IRQ_PULSE_EN
        check("alarm_irq", int'(alarm_irq), int'(e.irq));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; det = 1'b0; clr = 1'b0;

    // Reset then threshold at window cycles 2, 5, 8; clear with det in alarm
    cyc(1, 0, 0, 0); cyc(1, 1, 1, 1);
    cyc(0, 1, 1, 0);
    window(16'h0124);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Window expiry below threshold
    cyc(0, 1, 0, 0);
    window(16'h0408);
    window(16'h0082);
    cyc(0, 0, 0, 0);

    // Third hit on the final window cycle, then two-hit variant
    cyc(0, 1, 0, 0);
    window(16'h8208);
    cyc(0, 1, 0, 0); cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    window(16'h0208);
    window(16'h0000);
    cyc(0, 0, 1, 0);

    // Disable mid-window, then synchronous reset in ALARM
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);

    // Saturation: continuous hits, clearing every alarm
    for (int i = 0; i < 300; i++) cyc(0, 1, 1, m_alarm);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 24) == 0));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_hit_monitor.md
Name: seq_hit_monitor

Overview:
- Downstream consumer of the overlapping "101" Moore detector. Its det input connects directly to the detector output y.
- Counts detection hits in total and per fixed-length observation window.
- Raises a sticky alarm when the hits within one window reach a threshold.
- Sits between the detector and the status/interrupt logic.

Parameters:
- WIN_LEN, 16: window length in clock cycles; legal range >= 2.
- THRESH, 3: hits within one window that trigger the alarm; legal range 1..WIN_LEN.
- CNT_W, 8: width of the total hit counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset: synchronous, active-high. Overrides every other input.
- en  input  1  monitor enable.
- det  input  1  detector output; each cycle high counts as one hit.
- clr  input  1  alarm/window clear, one-cycle strobe.
- hit_cnt  output  CNT_W  total hits since reset; saturates at all-ones.
- win_cnt  output  $clog2(THRESH+1)  hits counted in the current window.
- alarm  output  1  registered sticky alarm.
- state_o  output  2  current FSM state, for debug.

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE; timer=0; hit_cnt=0; win_cnt=0; alarm=0.
  - Any det/clr/en in that cycle is ignored.
- FSM states: IDLE=2'b00, WATCH=2'b01, ALARM=2'b10. 2'b11 is illegal and goes to IDLE on the next clock with all counters cleared.
- IDLE:
  - timer and win_cnt held at 0; alarm=0.
  - en=1 -> WATCH next cycle.
  - det is ignored in IDLE, including the en-rising cycle.
- WATCH (each cycle, with h = en & det):
  - hit_cnt += h, saturating.
  - If win_cnt + h >= THRESH -> ALARM next cycle; alarm=1 and win_cnt=THRESH on that edge. Alarm latency is one cycle after the hit that reaches the threshold.
  - Else if timer == WIN_LEN-1 -> timer=0, win_cnt=0. The hit on the final window cycle is evaluated before the restart and is not carried into the next window.
  - Else -> timer += 1, win_cnt += h.
- ALARM:
  - timer and win_cnt frozen; alarm stays 1.
  - hit_cnt keeps counting det while en=1.
- clr=1 in WATCH or ALARM:
  - -> WATCH with timer=0, win_cnt=0, alarm=0.
  - The det of the clr cycle counts in hit_cnt only, not in win_cnt.
- en=0 in WATCH or ALARM:
  - -> IDLE; timer=0, win_cnt=0, alarm=0; hit_cnt holds its value.
- Priority: rst > en=0 > clr > threshold > window wrap.
- Threshold reached on the final window cycle: the alarm wins; the window does not restart.
- hit_cnt at 2^CNT_W-1 stays at that value; it never wraps.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_HIT_MONITOR_IRQ_PULSE_EN.
- When defined:
  - Adds output port alarm_irq, 1 bit, registered.
  - alarm_irq is high for exactly one cycle: the cycle alarm first rises (WATCH->ALARM transition).
  - Re-arms after clr or en=0.
- When undefined: the port does not exist and there is no related logic.

Decomposition:
- Package seq_mon_pkg holds:
  - 2-bit state typedef with the encodings IDLE/WATCH/ALARM above;
  - the localparam for the illegal-state code.
- Sub-module seq_win_timer:
  - free-running window counter 0..WIN_LEN-1 with clear and hold inputs;
  - outputs a last-cycle flag;
  - parameter WIN_LEN.
- The FSM, hit counters and alarm stay in the top module.

Test Plan (WIN_LEN=16, THRESH=3, CNT_W=8):
- Reset, then hit threshold:
  - rst high 2 cycles, then en=1 and det pulses at cycles 2, 5, 8 of the window.
  - Expect win_cnt 1, 2, 3; alarm=1 on the cycle after the third hit.
  - hit_cnt=3; state_o=2'b10.
- Window expiry below threshold:
  - 2 hits in window 1, 2 hits in window 2.
  - Expect win_cnt back to 0 after cycle 15, alarm never set, hit_cnt=4.
- Hit on final window cycle:
  - hits at window cycles 3 and 9, third hit at cycle 15.
  - Expect alarm=1 next cycle and no window restart.
  - Same stimulus with only 2 hits: expect the window restarts and win_cnt=0.
- Clear behaviour:
  - In ALARM, assert clr together with det=1.
  - Expect alarm=0, state WATCH, win_cnt=0, hit_cnt incremented by 1.
- Disable mid-window:
  - en=0 with win_cnt=2.
  - Expect IDLE, win_cnt=0, hit_cnt held.
  - Synchronous rst mid-ALARM clears everything on the next edge only.
- Saturation and IRQ:
  - Apply 260 hits with clr pulsed after each alarm.
  - Expect hit_cnt=255, held, never wrapping.
  - With SEQ_HIT_MONITOR_IRQ_PULSE_EN defined, alarm_irq is high for exactly one cycle per alarm entry.
